// File: rtl/handshake_const_checker.sv
// handshake_const_checker
//   Consumer end of a constant-producing handshake channel. Each accepted data
//   token is compared against EXPECTED and turned back into a dataless control
//   token through a one-slot output register. Match/mismatch counters saturate.
//   A sticky error flag and the last offending payload are kept for debug.
//
//   Optional build macro: HANDSHAKE_CONST_CHECKER_HALT_EN
//     defined   : once err is set, ins_ready is held low until clr or rst.
//     undefined : err is informational only; the stream never stalls on it.
module handshake_const_checker #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] EXPECTED   = 32'h0007_0A3A,
  parameter int          CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic                  ctrl_valid,
  input  logic                  ctrl_ready,
  output logic [CNT_WIDTH-1:0]  match_cnt,
  output logic [CNT_WIDTH-1:0]  mismatch_cnt,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] last_bad
);

  // Reference value, zero-extended or truncated to the payload width.
  localparam logic [DATA_WIDTH-1:0] EXP_VAL = DATA_WIDTH'(EXPECTED);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;

  logic                  r_full;
  logic [CNT_WIDTH-1:0]  r_match_cnt;
  logic [CNT_WIDTH-1:0]  r_mismatch_cnt;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_last_bad;

  logic w_halt;
  logic w_slot_free;
  logic w_in_xfer;
  logic w_out_xfer;
  logic w_is_match;

`ifdef HANDSHAKE_CONST_CHECKER_HALT_EN
  // Stop accepting new tokens while an error is latched; the slot still drains.
  assign w_halt = r_err;
`else
  assign w_halt = 1'b0;
`endif

  // The slot can take a new token if it is empty or is emptied this cycle.
  // ins_valid never feeds ins_ready, so no combinational loop is formed.
  assign w_slot_free = !r_full || ctrl_ready;
  assign ins_ready   = w_slot_free && !w_halt;
  assign ctrl_valid  = r_full;

  assign w_in_xfer  = ins_valid && ins_ready;
  assign w_out_xfer = r_full && ctrl_ready;
  assign w_is_match = (ins == EXP_VAL);

  assign match_cnt    = r_match_cnt;
  assign mismatch_cnt = r_mismatch_cnt;
  assign err          = r_err;
  assign last_bad     = r_last_bad;

  // Output slot occupancy: fill on input, empty on output, stay full on both.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full <= 1'b0;
    end else if (w_in_xfer) begin
      r_full <= 1'b1;
    end else if (w_out_xfer) begin
      r_full <= 1'b0;
    end
  end

  // Compare statistics; clr wins over a same-cycle accepted beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_match_cnt    <= '0;
      r_mismatch_cnt <= '0;
      r_err          <= 1'b0;
      r_last_bad     <= '0;
    end else if (clr) begin
      r_match_cnt    <= '0;
      r_mismatch_cnt <= '0;
      r_err          <= 1'b0;
      r_last_bad     <= '0;
    end else if (w_in_xfer) begin
      if (w_is_match) begin
        if (r_match_cnt != CNT_MAX) begin
          r_match_cnt <= r_match_cnt + CNT_WIDTH'(1);
        end
      end else begin
        if (r_mismatch_cnt != CNT_MAX) begin
          r_mismatch_cnt <= r_mismatch_cnt + CNT_WIDTH'(1);
        end
        r_err      <= 1'b1;
        r_last_bad <= ins;
      end
    end
  end

endmodule

// File: tb/tb_handshake_const_checker.sv
// Testbench for handshake_const_checker: directed table, hand-written corner
// sequences and randomized traffic checked against a token-level model.
module tb_handshake_const_checker;

  localparam int          CW   = 4;
  localparam int          MAXC = (1 << CW) - 1;
  localparam logic [31:0] EXP  = 32'h0007_0A3A;
`ifdef HANDSHAKE_CONST_CHECKER_HALT_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          clr;
  logic [31:0]   ins;
  logic          ins_valid;
  logic          ins_ready;
  logic          ctrl_valid;
  logic          ctrl_ready;
  logic [CW-1:0] match_cnt;
  logic [CW-1:0] mismatch_cnt;
  logic          err;
  logic [31:0]   last_bad;

  handshake_const_checker #(
    .DATA_WIDTH(32),
    .EXPECTED  (EXP),
    .CNT_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .ins         (ins),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready),
    .ctrl_valid  (ctrl_valid),
    .ctrl_ready  (ctrl_ready),
    .match_cnt   (match_cnt),
    .mismatch_cnt(mismatch_cnt),
    .err         (err),
    .last_bad    (last_bad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Token-level model state.
  int          m_slot;
  int          m_match;
  int          m_mis;
  bit          m_err;
  logic [31:0] m_lb;
  int          m_deliv = 0;
  int          dut_deliv = 0;

  // Count control tokens actually handed downstream by the DUT.
  always @(posedge clk) begin
    if (rst && ctrl_valid && ctrl_ready) dut_deliv <= dut_deliv + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_slot  = 0;
    m_match = 0;
    m_mis   = 0;
    m_err   = 1'b0;
    m_lb    = '0;
  endtask

  function automatic bit model_ready(input bit cr);
    return (m_slot == 0 || cr) && !(HALT && m_err);
  endfunction

  task automatic drive(input bit c, input bit v, input logic [31:0] d, input bit cr);
    @(negedge clk);
    clr        = c;
    ins_valid  = v;
    ins        = d;
    ctrl_ready = cr;
    #1;
  endtask

  // Compare against the model, then advance the model across the next edge.
  task automatic commit();
    bit in_x;
    bit out_x;
    chk("ins_ready",    32'(ins_ready),    32'(model_ready(ctrl_ready)));
    chk("ctrl_valid",   32'(ctrl_valid),   32'(m_slot));
    chk("match_cnt",    32'(match_cnt),    32'(m_match));
    chk("mismatch_cnt", 32'(mismatch_cnt), 32'(m_mis));
    chk("err",          32'(err),          32'(m_err));
    chk("last_bad",     last_bad,          m_lb);
    in_x  = ins_valid && model_ready(ctrl_ready);
    out_x = (m_slot == 1) && ctrl_ready;
    @(posedge clk);
    m_slot  = m_slot + int'(in_x) - int'(out_x);
    m_deliv = m_deliv + int'(out_x);
    if (clr) begin
      m_match = 0;
      m_mis   = 0;
      m_err   = 1'b0;
      m_lb    = '0;
    end else if (in_x) begin
      if (ins == EXP) begin
        m_match = (m_match < MAXC) ? m_match + 1 : MAXC;
      end else begin
        m_mis = (m_mis < MAXC) ? m_mis + 1 : MAXC;
        m_err = 1'b1;
        m_lb  = ins;
      end
    end
    $display("cyc t=%0t clr=%0b v=%0b ins=%h cr=%0b | rdy=%0b cv=%0b m=%0d mis=%0d err=%0b",
             $time, clr, ins_valid, ins, ctrl_ready, ins_ready, ctrl_valid,
             match_cnt, mismatch_cnt, err);
  endtask

  task automatic step(input bit c, input bit v, input logic [31:0] d, input bit cr);
    drive(c, v, d, cr);
    commit();
  endtask

  // Directed vectors: inputs plus the outputs expected while they are applied.
  typedef struct {
    bit          c;
    bit          v;
    logic [31:0] d;
    bit          cr;
    bit          rdy;
    bit          cv;
    int          m;
    int          mis;
    bit          e;
    logic [31:0] lb;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // Stall then drain, then match/mismatch/match with clr at the end.
    tbl[0]  = '{0, 1, EXP, 1,  1, 0, 0, 0, 0, 32'h0};
    tbl[1]  = '{0, 1, EXP, 0,  0, 1, 1, 0, 0, 32'h0};
    tbl[2]  = '{0, 1, EXP, 0,  0, 1, 1, 0, 0, 32'h0};
    tbl[3]  = '{0, 1, EXP, 0,  0, 1, 1, 0, 0, 32'h0};
    tbl[4]  = '{0, 1, EXP, 0,  0, 1, 1, 0, 0, 32'h0};
    tbl[5]  = '{0, 1, EXP, 1,  1, 1, 1, 0, 0, 32'h0};
    tbl[6]  = '{0, 1, EXP, 1,  1, 1, 2, 0, 0, 32'h0};
    tbl[7]  = '{0, 0, 32'h0, 1, 1, 1, 3, 0, 0, 32'h0};
    tbl[8]  = '{0, 0, 32'h0, 1, 1, 0, 3, 0, 0, 32'h0};
    tbl[9]  = '{0, 1, EXP, 1,  1, 0, 3, 0, 0, 32'h0};
    tbl[10] = '{0, 1, 32'h0001_2345, 1, 1, 1, 4, 0, 0, 32'h0};
    tbl[11] = '{0, 1, EXP, 1,  (HALT ? 0 : 1), 1, 4, 1, 1, 32'h0001_2345};
    tbl[12] = '{0, 0, 32'h0, 1, (HALT ? 0 : 1), (HALT ? 0 : 1), (HALT ? 4 : 5), 1, 1, 32'h0001_2345};
    tbl[13] = '{1, 1, EXP, 1,  (HALT ? 0 : 1), 0, (HALT ? 4 : 5), 1, 1, 32'h0001_2345};
    tbl[14] = '{0, 0, 32'h0, 1, 1, (HALT ? 0 : 1), 0, 0, 0, 32'h0};

    rst        = 1'b0;
    clr        = 1'b0;
    ins        = '0;
    ins_valid  = 1'b0;
    ctrl_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl_valid", 32'(ctrl_valid), 32'd0);
    chk("rst_match",      32'(match_cnt),  32'd0);
    chk("rst_mismatch",   32'(mismatch_cnt), 32'd0);
    chk("rst_err",        32'(err),        32'd0);
    chk("rst_last_bad",   last_bad,        32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Five back-to-back matching tokens with a permanently ready sink.
    repeat (5) step(0, 1, EXP, 1);
    drive(0, 0, 32'h0, 1);
    chk("b2b_match",    32'(match_cnt),    32'd5);
    chk("b2b_mismatch", 32'(mismatch_cnt), 32'd0);
    chk("b2b_err",      32'(err),          32'd0);
    chk("b2b_cvalid",   32'(ctrl_valid),   32'd1);
    commit();
    step(1, 0, 32'h0, 1);

    // Table-driven directed sequence.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].c, tbl[i].v, tbl[i].d, tbl[i].cr);
      chk($sformatf("tbl%0d_rdy", i), 32'(ins_ready),    32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_cv", i),  32'(ctrl_valid),   32'(tbl[i].cv));
      chk($sformatf("tbl%0d_m", i),   32'(match_cnt),    32'(tbl[i].m));
      chk($sformatf("tbl%0d_mis", i), 32'(mismatch_cnt), 32'(tbl[i].mis));
      chk($sformatf("tbl%0d_err", i), 32'(err),          32'(tbl[i].e));
      chk($sformatf("tbl%0d_lb", i),  last_bad,          tbl[i].lb);
      commit();
    end
    step(0, 0, 32'h0, 1);

    // Saturation, then clr together with a matching transfer.
    step(1, 0, 32'h0, 1);
    repeat (MAXC + 3) step(0, 1, EXP, 1);
    drive(0, 0, 32'h0, 1);
    chk("sat_match", 32'(match_cnt), 32'(MAXC));
    commit();
    step(1, 1, EXP, 1);
    drive(0, 0, 32'h0, 1);
    chk("clr_xfer_match",  32'(match_cnt),  32'd0);
    chk("clr_xfer_cvalid", 32'(ctrl_valid), 32'd1);
    commit();

    // Asynchronous reset while a token is stuck in the slot.
    step(0, 1, 32'h0000_0005, 1);
    step(0, 0, 32'h0, 0);
    drive(0, 0, 32'h0, 0);
    chk("pre_rst_cvalid", 32'(ctrl_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_cvalid",   32'(ctrl_valid),   32'd0);
    chk("arst_match",    32'(match_cnt),    32'd0);
    chk("arst_mismatch", 32'(mismatch_cnt), 32'd0);
    chk("arst_err",      32'(err),          32'd0);
    chk("arst_last_bad", last_bad,          32'd0);
    chk("arst_ready",    32'(ins_ready),    32'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(0, 1, EXP, 1);
    step(0, 0, 32'h0, 1);

    // Mismatch followed by a match offered persistently; halt builds stall.
    step(1, 0, 32'h0, 1);
    step(0, 1, 32'h0000_0001, 1);
    repeat (3) step(0, 1, EXP, 1);
    drive(0, 0, 32'h0, 1);
    chk("halt_match", 32'(match_cnt), HALT ? 32'd0 : 32'd3);
    chk("halt_ready", 32'(ins_ready), HALT ? 32'd0 : 32'd1);
    chk("halt_err",   32'(err),       32'd1);
    commit();
    step(1, 1, EXP, 1);
    step(0, 1, EXP, 1);
    drive(0, 0, 32'h0, 1);
    chk("release_match", 32'(match_cnt), 32'd1);
    chk("release_err",   32'(err),       32'd0);
    commit();

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 15) == 0,
           $urandom_range(0, 9) < 7,
           ($urandom_range(0, 1) == 1) ? EXP : 32'($urandom),
           $urandom_range(0, 9) < 7);
    end
    step(0, 0, 32'h0, 1);
    step(0, 0, 32'h0, 1);
    chk("delivered", 32'(dut_deliv), 32'(m_deliv));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
